lut_sweep_checker: RTL and testbench

- Parametrised N-input boolean-function engine: holds a programmable 2^N-entry truth table and evaluates it on demand (registered).
- Also runs an exhaustive sweep: drives every input vector 0..2^N-1 to an external gate-level implementation, samples its output, compares against the table, and reports error count and first failing vector.
- Successor to the fixed 4-input NAND-realisation-plus-exhaustive-bench pattern: the golden model and the sweep become reusable RTL.

---
 rtl/lut_sweep_checker_if.sv | 37 +++
 rtl/lut_sweep_checker.sv | 150 +++++++++++++++
 tb/tb_lut_sweep_checker.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_sweep_checker_if.sv
// Bundle between lut_sweep_checker and its environment:
// table programming, direct evaluation, sweep bus and sweep results.
interface lut_sweep_checker_if #(
    parameter int N = 4
);
    logic         cfg_we;
    logic [N-1:0] cfg_addr;
    logic         cfg_data;
    logic [N-1:0] eval_in;
    logic         eval_out;
    logic         start;
    logic         dut_f;
    logic [N-1:0] sweep_vec;
    logic         sweep_valid;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic [N-1:0] first_fail;
    logic         first_fail_valid;

    modport master (
        output cfg_we, cfg_addr, cfg_data,
        output eval_in, start, dut_f,
        input  eval_out, sweep_vec, sweep_valid,
        input  busy, done, pass,
        input  err_count, first_fail, first_fail_valid
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data,
        input  eval_in, start, dut_f,
        output eval_out, sweep_vec, sweep_valid,
        output busy, done, pass,
        output err_count, first_fail, first_fail_valid
    );
endinterface

// File: rtl/lut_sweep_checker.sv
// Programmable N-input truth table with registered evaluation and an
// exhaustive sweep that checks an external implementation against it.
module lut_sweep_checker #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    lut_sweep_checker_if.slave   bus
);
    localparam int           DEPTH    = 1 << N;
    localparam logic [N-1:0] LAST_VEC = '1;
    localparam logic [N:0]   ERR_MAX  = {1'b1, {N{1'b0}}};
    localparam logic [7:0]   SET_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] table_q, table_d;
    logic             eval_q, eval_d;
    logic [N-1:0]     vec_q, vec_d;
    logic [7:0]       settle_q, settle_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N:0]       err_q, err_d;
    logic [N-1:0]     ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic             mismatch;

    // Table writes are locked out while a sweep is running.
    always_comb begin
        table_d = table_q;
        if (bus.cfg_we && !busy_q) begin
            table_d[bus.cfg_addr] = bus.cfg_data;
        end
    end

    // Direct evaluation reads the pre-write table, one cycle latency.
    always_comb begin
        eval_d = table_q[bus.eval_in];
    end

    // Sweep sequencer: next state, vector stepping and result capture.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        mismatch = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d    = '0;
                    ff_d     = '0;
                    ffv_d    = 1'b0;
                    vec_d    = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    valid_d  = 1'b1;
                    pass_d   = 1'b0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                settle_d = settle_q + 8'd1;
                if (settle_q == SET_LAST) begin
                    mismatch = bus.dut_f != table_q[vec_q];
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!ffv_q) begin
                            ff_d  = vec_q;
                            ffv_d = 1'b1;
                        end
                    end
                    settle_d = '0;
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; rst abandons any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            table_q  <= '0;
            eval_q   <= 1'b0;
            vec_q    <= '0;
            settle_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ff_q     <= '0;
            ffv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            table_q  <= table_d;
            eval_q   <= eval_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
            ffv_q    <= ffv_d;
        end
    end

    assign bus.eval_out         = eval_q;
    assign bus.sweep_vec        = vec_q;
    assign bus.sweep_valid      = valid_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail       = ff_q;
    assign bus.first_fail_valid = ffv_q;
endmodule

// File: tb/tb_lut_sweep_checker.sv
// Scoreboard bench for lut_sweep_checker: three instances cover
// N=4/SETTLE=1, N=4/SETTLE=3 and N=2/SETTLE=1.
module tb_lut_sweep_checker;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lut_sweep_checker_if #(.N(4)) b0();
    lut_sweep_checker_if #(.N(4)) b1();
    lut_sweep_checker_if #(.N(2)) b2();

    lut_sweep_checker #(.N(4), .SETTLE(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    lut_sweep_checker #(.N(4), .SETTLE(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    lut_sweep_checker #(.N(2), .SETTLE(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct {
        int err;
        int ff;
        bit ffv;
        bit pass;
        int lat;
        int t0;
    } res_t;

    typedef struct {
        int   idx;
        logic val;
    } ev_t;

    res_t q0[$];
    res_t q1[$];
    res_t q2[$];
    ev_t  evq[$];
    logic evgo = 1'b0;
    logic evchk = 1'b0;
    bit   fault0 = 1'b0;
    bit   inv2 = 1'b0;
    bit [15:0] golden = 16'h1F55;
    bit [3:0]  xtab = 4'b0110;

    // F = wx' + y'z' + w'z' as a two-level NAND network (w is bit 3).
    function automatic logic nand_f(input logic [3:0] v);
        logic a, b, c;
        a = ~(v[3] & ~v[2]);
        b = ~(~v[1] & ~v[0]);
        c = ~(~v[3] & ~v[0]);
        return ~(a & b & c);
    endfunction

    assign b0.dut_f = nand_f(b0.sweep_vec) |
                      (fault0 && (b0.sweep_vec == 4'd5 || b0.sweep_vec == 4'd14));
    assign b1.dut_f = nand_f(b1.sweep_vec);
    assign b2.dut_f = (b2.sweep_vec[1] ^ b2.sweep_vec[0]) ^ inv2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t e, input int err,
                           input int ff, input logic ffv, input logic pass);
        chk({tag, " err_count"}, 32'(err), 32'(e.err));
        chk({tag, " first_fail"}, 32'(ff), 32'(e.ff));
        chk({tag, " first_fail_valid"}, 32'(ffv), 32'(e.ffv));
        chk({tag, " pass"}, 32'(pass), 32'(e.pass));
        chk({tag, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
    endtask

    task automatic no_exp(input string tag);
        total++;
        bad++;
        $display("FAIL %s: unexpected done pulse", tag);
    endtask

    // Result monitors: pop an expectation on every done pulse.
    always @(negedge clk) begin
        if (!rst && b0.done) begin
            if (q0.size() == 0) no_exp("u0 done");
            else cmp_res("u0", q0.pop_front(), 32'(b0.err_count),
                         32'(b0.first_fail), b0.first_fail_valid, b0.pass);
        end
    end

    always @(negedge clk) begin
        if (!rst && b1.done) begin
            if (q1.size() == 0) no_exp("u1 done");
            else cmp_res("u1", q1.pop_front(), 32'(b1.err_count),
                         32'(b1.first_fail), b1.first_fail_valid, b1.pass);
        end
    end

    always @(negedge clk) begin
        if (!rst && b2.done) begin
            if (q2.size() == 0) no_exp("u2 done");
            else cmp_res("u2", q2.pop_front(), 32'(b2.err_count),
                         32'(b2.first_fail), b2.first_fail_valid, b2.pass);
        end
    end

    // Evaluation monitor: eval_out is due one edge after the request.
    always @(posedge clk) evchk <= evgo;

    always @(negedge clk) begin
        if (evchk && evq.size() != 0) begin
            ev_t e;
            e = evq.pop_front();
            chk($sformatf("eval[%0d]", e.idx), 32'(b0.eval_out), 32'(e.val));
        end
    end

    // SETTLE=3 instance: every vector must be held exactly 3 cycles.
    logic [3:0] pv;
    bit         pvalid = 1'b0;
    int         run = 0;
    always @(negedge clk) begin
        if (rst) begin
            pvalid = 1'b0;
            run = 0;
        end else if (b1.sweep_valid) begin
            if (pvalid && b1.sweep_vec == pv) begin
                run++;
            end else begin
                if (pvalid) chk($sformatf("u1 hold vec %0d", pv), 32'(run), 32'd3);
                run = 1;
            end
            pv = b1.sweep_vec;
            pvalid = 1'b1;
        end else if (pvalid) begin
            chk("u1 hold last vec", 32'(run), 32'd3);
            pvalid = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr0(input logic [3:0] a, input logic d);
        b0.cfg_we = 1'b1;
        b0.cfg_addr = a;
        b0.cfg_data = d;
        tick(1);
        b0.cfg_we = 1'b0;
    endtask

    task automatic ev0(input logic [3:0] i, input logic e);
        b0.eval_in = i;
        evgo = 1'b1;
        evq.push_back('{idx: int'(i), val: e});
        tick(1);
        evgo = 1'b0;
    endtask

    task automatic ev_same(input logic [3:0] i, input logic wd, input logic old);
        b0.cfg_we = 1'b1;
        b0.cfg_addr = i;
        b0.cfg_data = wd;
        b0.eval_in = i;
        evgo = 1'b1;
        evq.push_back('{idx: int'(i), val: old});
        tick(1);
        b0.cfg_we = 1'b0;
        evgo = 1'b0;
    endtask

    task automatic go(input int w, input res_t e);
        e.t0 = cyc + 1;
        case (w)
            0: begin q0.push_back(e); b0.start = 1'b1; end
            1: begin q1.push_back(e); b1.start = 1'b1; end
            default: begin q2.push_back(e); b2.start = 1'b1; end
        endcase
        tick(1);
        b0.start = 1'b0;
        b1.start = 1'b0;
        b2.start = 1'b0;
    endtask

    task automatic wait_done(input int w, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            case (w)
                0: seen = b0.done;
                1: seen = b1.done;
                default: seen = b2.done;
            endcase
        end
        chk($sformatf("u%0d done within budget", w), 32'(seen), 32'd1);
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, " eval_out"}, 32'(b0.eval_out), 32'd0);
        chk({tag, " sweep_vec"}, 32'(b0.sweep_vec), 32'd0);
        chk({tag, " sweep_valid"}, 32'(b0.sweep_valid), 32'd0);
        chk({tag, " busy"}, 32'(b0.busy), 32'd0);
        chk({tag, " done"}, 32'(b0.done), 32'd0);
        chk({tag, " pass"}, 32'(b0.pass), 32'd0);
        chk({tag, " err_count"}, 32'(b0.err_count), 32'd0);
        chk({tag, " first_fail"}, 32'(b0.first_fail), 32'd0);
        chk({tag, " first_fail_valid"}, 32'(b0.first_fail_valid), 32'd0);
    endtask

    initial begin
        b0.cfg_we = 0; b0.cfg_addr = '0; b0.cfg_data = 0; b0.eval_in = '0; b0.start = 0;
        b1.cfg_we = 0; b1.cfg_addr = '0; b1.cfg_data = 0; b1.eval_in = '0; b1.start = 0;
        b2.cfg_we = 0; b2.cfg_addr = '0; b2.cfg_data = 0; b2.eval_in = '0; b2.start = 0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_idle0("power-up");

        // Reset in the middle of a sweep: abandoned, no done, table cleared.
        wr0(4'd3, 1'b1);
        b0.start = 1'b1;
        tick(1);
        b0.start = 1'b0;
        tick(4);
        chk("mid-sweep busy", 32'(b0.busy), 32'd1);
        chk("mid-sweep sweep_valid", 32'(b0.sweep_valid), 32'd1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_idle0("after rst");
        ev0(4'd3, 1'b0);
        ev0(4'd0, 1'b0);
        tick(20);
        chk("after rst busy stays low", 32'(b0.busy), 32'd0);

        // Program 0x1F55 into both N=4 instances and XOR into N=2.
        for (int i = 0; i < 16; i++) begin
            b0.cfg_we = 1'b1; b0.cfg_addr = 4'(i); b0.cfg_data = golden[i];
            b1.cfg_we = 1'b1; b1.cfg_addr = 4'(i); b1.cfg_data = golden[i];
            b2.cfg_we = (i < 4);
            b2.cfg_addr = 2'(i);
            b2.cfg_data = xtab[i % 4];
            tick(1);
        end
        b0.cfg_we = 0; b1.cfg_we = 0; b2.cfg_we = 0;

        for (int i = 0; i < 16; i++) ev0(4'(i), golden[i]);
        wr0(4'd13, 1'b1);
        ev0(4'd13, 1'b1);
        ev_same(4'd13, 1'b0, 1'b1);
        ev0(4'd13, 1'b0);
        tick(1);

        // Passing sweep against the NAND network.
        go(0, '{err: 0, ff: 0, ffv: 0, pass: 1, lat: 16, t0: 0});
        wait_done(0, 40);
        tick(1);

        // Stuck-at-1 faults at vectors 5 and 14.
        fault0 = 1'b1;
        go(0, '{err: 2, ff: 5, ffv: 1, pass: 0, lat: 16, t0: 0});
        wait_done(0, 40);
        tick(3);
        fault0 = 1'b0;
        chk("u0 hold err_count", 32'(b0.err_count), 32'd2);
        chk("u0 hold first_fail", 32'(b0.first_fail), 32'd5);
        chk("u0 hold pass", 32'(b0.pass), 32'd0);

        // SETTLE=3: mid-sweep writes and starts must be ignored.
        go(1, '{err: 0, ff: 0, ffv: 0, pass: 1, lat: 48, t0: 0});
        tick(10);
        b1.cfg_we = 1'b1; b1.cfg_addr = 4'd15; b1.cfg_data = 1'b1;
        tick(1);
        b1.cfg_addr = 4'd0; b1.cfg_data = 1'b0;
        tick(1);
        b1.cfg_we = 1'b0;
        b1.start = 1'b1;
        tick(1);
        b1.start = 1'b0;
        wait_done(1, 80);
        tick(1);
        go(1, '{err: 0, ff: 0, ffv: 0, pass: 1, lat: 48, t0: 0});
        wait_done(1, 80);
        tick(1);

        // N=2, every vector wrong, then start during the done cycle.
        inv2 = 1'b1;
        go(2, '{err: 4, ff: 0, ffv: 1, pass: 0, lat: 4, t0: 0});
        wait_done(2, 20);
        b2.start = 1'b1;
        tick(1);
        b2.start = 1'b0;
        chk("u2 start at done ignored", 32'(b2.busy), 32'd0);
        inv2 = 1'b0;
        go(2, '{err: 0, ff: 0, ffv: 0, pass: 1, lat: 4, t0: 0});
        wait_done(2, 20);
        tick(3);

        chk("u0 pending results", 32'(q0.size()), 32'd0);
        chk("u1 pending results", 32'(q1.size()), 32'd0);
        chk("u2 pending results", 32'(q2.size()), 32'd0);
        chk("pending evals", 32'(evq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
